load_unit: RTL and testbench

- Executes RISC-V integer loads (LB/LH/LW/LD/LBU/LHU/LWU) for the rv64 datapath.
- Acts as an AXI4-Lite read master on the data-memory port.
- Is the read-side counterpart of the store path: it issues one AR transaction per load, extracts and extends the addressed lane from R data, and returns a tagged result to writeback.
- Only one load is in flight at a time.

---
 rtl/load_unit.sv | 175 +++++++++++++++++
 tb/tb_load_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_unit.sv
// RV64 integer load unit: issues one AXI4-Lite read per load, extracts and
// extends the addressed lane, and returns a tagged result to writeback.
module load_unit #(
  parameter int XLEN = 64,
  parameter int ALEN = XLEN,
  parameter int DLEN = XLEN,
  parameter int SLEN = DLEN / 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_tvalid,
  output logic            o_tready,
  input  logic [XLEN-1:0] i_base_addr,
  input  logic [XLEN-1:0] i_offset,
  input  logic [2:0]      i_width,
  input  logic [4:0]      i_rd,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd,
  output logic [1:0]      o_err,
  output logic            o_dm_arvalid,
  input  logic            i_dm_arready,
  output logic [ALEN-1:0] o_dm_araddr,
  output logic [2:0]      o_dm_arprot,
  input  logic            i_dm_rvalid,
  output logic            o_dm_rready,
  input  logic [DLEN-1:0] i_dm_rdata,
  input  logic [1:0]      i_dm_rresp
);

  localparam int LaneW = $clog2(SLEN);

  localparam logic [1:0] ErrNone     = 2'b00;
  localparam logic [1:0] ErrMisalign = 2'b01;
  localparam logic [1:0] ErrBus      = 2'b10;
  localparam logic [1:0] ErrIllegal  = 2'b11;

  if (ALEN < XLEN) begin : g_chk_alen
    $error("load_unit: ALEN must be >= XLEN");
  end
  if (DLEN < XLEN || DLEN < 64 || (DLEN & (DLEN - 1)) != 0) begin : g_chk_dlen
    $error("load_unit: DLEN must be a power of two >= max(XLEN, 64)");
  end

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_e;

  state_e           state_q;
  logic             tready_q;
  logic             valid_q;
  logic             arvalid_q;
  logic             rready_q;
  logic [XLEN-1:0]  result_q;
  logic [4:0]       rd_q;
  logic [1:0]       err_q;
  logic [ALEN-1:0]  araddr_q;
  logic [LaneW-1:0] lane_q;
  logic [2:0]       width_q;

  logic [XLEN-1:0]  req_addr_d;
  logic             misaligned_d;
  logic [DLEN-1:0]  beat_shifted;
  logic [XLEN-1:0]  load_data_d;

  // Effective address wraps modulo 2^XLEN; only alignment is ever checked.
  assign req_addr_d = i_base_addr + i_offset;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    misaligned_d = 1'b0;
    case (i_width[1:0])
      2'b01:   misaligned_d = req_addr_d[0];
      2'b10:   misaligned_d = |req_addr_d[1:0];
      2'b11:   misaligned_d = |req_addr_d[2:0];
      default: misaligned_d = 1'b0;
    endcase
  end

  assign beat_shifted = i_dm_rdata >> {lane_q, 3'b000};

  always_comb begin
    load_data_d = beat_shifted[XLEN-1:0];
    case (width_q)
      3'b000:  load_data_d = {{(XLEN-8){beat_shifted[7]}}, beat_shifted[7:0]};
      3'b001:  load_data_d = {{(XLEN-16){beat_shifted[15]}}, beat_shifted[15:0]};
      3'b010:  load_data_d = {{(XLEN-32){beat_shifted[31]}}, beat_shifted[31:0]};
      3'b100:  load_data_d = XLEN'(beat_shifted[7:0]);
      3'b101:  load_data_d = XLEN'(beat_shifted[15:0]);
      3'b110:  load_data_d = XLEN'(beat_shifted[31:0]);
      default: load_data_d = beat_shifted[XLEN-1:0];
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      tready_q  <= 1'b1;
      valid_q   <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      result_q  <= '0;
      rd_q      <= '0;
      err_q     <= ErrNone;
      araddr_q  <= '0;
      lane_q    <= '0;
      width_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_tvalid && tready_q) begin
            tready_q <= 1'b0;
            rd_q     <= i_rd;
            width_q  <= i_width;
            lane_q   <= req_addr_d[LaneW-1:0];
            result_q <= '0;
            if (i_width == 3'b111) begin
              err_q   <= ErrIllegal;
              valid_q <= 1'b1;
              state_q <= RESP;
            end else if (misaligned_d) begin
              err_q   <= ErrMisalign;
              valid_q <= 1'b1;
              state_q <= RESP;
            end else begin
              arvalid_q <= 1'b1;
              araddr_q  <= ALEN'(req_addr_d);
              state_q   <= ADDR;
            end
          end
        end
        ADDR: begin
          if (i_dm_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (i_dm_rvalid) begin
            rready_q <= 1'b0;
            valid_q  <= 1'b1;
            state_q  <= RESP;
            if (i_dm_rresp != 2'b00) begin
              result_q <= '0;
              err_q    <= ErrBus;
            end else begin
              result_q <= load_data_d;
              err_q    <= ErrNone;
            end
          end
        end
        RESP: begin
          if (i_ready) begin
            valid_q  <= 1'b0;
            tready_q <= 1'b1;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_tready     = tready_q;
  assign o_valid      = valid_q;
  assign o_result     = result_q;
  assign o_rd         = rd_q;
  assign o_err        = err_q;
  assign o_dm_arvalid = arvalid_q;
  assign o_dm_araddr  = araddr_q;
  assign o_dm_arprot  = 3'b000;
  assign o_dm_rready  = rready_q;

endmodule

// File: tb/tb_load_unit.sv
// Self-checking bench for load_unit: directed cases plus randomized loads
// compared against an arithmetic reference model of RV64 load semantics.
module tb_load_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_tvalid;
  logic        o_tready;
  logic [63:0] i_base_addr;
  logic [63:0] i_offset;
  logic [2:0]  i_width;
  logic [4:0]  i_rd;
  logic        o_valid;
  logic        i_ready;
  logic [63:0] o_result;
  logic [4:0]  o_rd;
  logic [1:0]  o_err;
  logic        o_dm_arvalid;
  logic        i_dm_arready;
  logic [63:0] o_dm_araddr;
  logic [2:0]  o_dm_arprot;
  logic        i_dm_rvalid;
  logic        o_dm_rready;
  logic [63:0] i_dm_rdata;
  logic [1:0]  i_dm_rresp;

  int n_cmp = 0;
  int n_bad = 0;
  int lat   = 0;

  load_unit dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_tvalid     (i_tvalid),
    .o_tready     (o_tready),
    .i_base_addr  (i_base_addr),
    .i_offset     (i_offset),
    .i_width      (i_width),
    .i_rd         (i_rd),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_result     (o_result),
    .o_rd         (o_rd),
    .o_err        (o_err),
    .o_dm_arvalid (o_dm_arvalid),
    .i_dm_arready (i_dm_arready),
    .o_dm_araddr  (o_dm_araddr),
    .o_dm_arprot  (o_dm_arprot),
    .i_dm_rvalid  (i_dm_rvalid),
    .o_dm_rready  (o_dm_rready),
    .i_dm_rdata   (i_dm_rdata),
    .i_dm_rresp   (i_dm_rresp)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    lat++;
  endtask

  // Reference: a load of 2^w bytes, lane taken from the low 3 address bits.
  function automatic void ref_load(input logic [63:0] addr, input logic [2:0] w,
                                   input logic [63:0] beat, input logic [1:0] resp,
                                   output logic [63:0] res, output logic [1:0] err,
                                   output bit uses_bus);
    int unsigned nbytes;
    logic [63:0] raw;
    logic [63:0] mask;
    res = 64'd0;
    err = 2'd0;
    uses_bus = 1'b0;
    if (w == 3'd7) begin
      err = 2'd3;
      return;
    end
    nbytes = 1 << w[1:0];
    if ((addr % 64'(nbytes)) != 64'd0) begin
      err = 2'd1;
      return;
    end
    uses_bus = 1'b1;
    if (resp != 2'd0) begin
      err = 2'd2;
      return;
    end
    raw  = beat >> (8 * (addr % 64'd8));
    mask = (nbytes == 8) ? '1 : ((64'd1 << (8 * nbytes)) - 64'd1);
    raw  = raw & mask;
    if (!w[2] && nbytes < 8 && raw[8*nbytes-1]) raw = raw | ~mask;
    res = raw;
  endfunction

  task automatic do_load(input logic [63:0] base, input logic [63:0] off,
                         input logic [2:0] w, input logic [4:0] rd,
                         input logic [63:0] beat, input logic [1:0] resp,
                         input int ar_d, input int r_d, input int rdy_d, input bit junk);
    logic [63:0] addr;
    logic [63:0] exp_res;
    logic [1:0]  exp_err;
    bit          uses_bus;
    addr = base + off;
    ref_load(addr, w, beat, resp, exp_res, exp_err, uses_bus);
    check("tready_idle", 64'(o_tready), 64'd1);
    i_tvalid = 1'b1;
    i_base_addr = base;
    i_offset = off;
    i_width = w;
    i_rd = rd;
    lat = 0;
    step();
    i_tvalid = 1'b0;
    if (uses_bus) begin
      check("arvalid", 64'(o_dm_arvalid), 64'd1);
      check("araddr", o_dm_araddr, addr);
      for (int k = 0; k < ar_d; k++) begin
        i_dm_rvalid = junk;
        i_dm_rdata  = ~beat;
        i_dm_rresp  = 2'b10;
        step();
        check("arvalid_hold", 64'(o_dm_arvalid), 64'd1);
        check("araddr_hold", o_dm_araddr, addr);
        check("rready_early", 64'(o_dm_rready), 64'd0);
      end
      i_dm_rvalid  = 1'b0;
      i_dm_arready = 1'b1;
      step();
      i_dm_arready = 1'b0;
      check("arvalid_clr", 64'(o_dm_arvalid), 64'd0);
      check("rready_set", 64'(o_dm_rready), 64'd1);
      for (int k = 0; k < r_d; k++) begin
        step();
        check("rready_wait", 64'(o_dm_rready), 64'd1);
        check("valid_wait", 64'(o_valid), 64'd0);
      end
      i_dm_rvalid = 1'b1;
      i_dm_rdata  = beat;
      i_dm_rresp  = resp;
      step();
      i_dm_rvalid = 1'b0;
      check("rready_clr", 64'(o_dm_rready), 64'd0);
      check("latency", 64'(lat), 64'(3 + ar_d + r_d));
    end else begin
      check("no_arvalid", 64'(o_dm_arvalid), 64'd0);
      check("latency_err", 64'(lat), 64'd1);
    end
    check("valid", 64'(o_valid), 64'd1);
    check("result", o_result, exp_res);
    check("err", 64'(o_err), 64'(exp_err));
    check("rd", 64'(o_rd), 64'(rd));
    check("tready_busy", 64'(o_tready), 64'd0);
    for (int k = 0; k < rdy_d; k++) begin
      step();
      check("valid_hold", 64'(o_valid), 64'd1);
      check("result_hold", o_result, exp_res);
      check("err_hold", 64'(o_err), 64'(exp_err));
      check("rd_hold", 64'(o_rd), 64'(rd));
      check("tready_hold", 64'(o_tready), 64'd0);
    end
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    check("valid_done", 64'(o_valid), 64'd0);
    check("tready_back", 64'(o_tready), 64'd1);
  endtask

  initial begin
    logic [63:0] addr;
    logic [63:0] off;
    logic [63:0] r64;
    logic [2:0]  w;
    rstn = 1'b0;
    i_tvalid = 1'b0;
    i_base_addr = '0;
    i_offset = '0;
    i_width = '0;
    i_rd = '0;
    i_ready = 1'b0;
    i_dm_arready = 1'b0;
    i_dm_rvalid = 1'b0;
    i_dm_rdata = '0;
    i_dm_rresp = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tready", 64'(o_tready), 64'd1);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_arvalid", 64'(o_dm_arvalid), 64'd0);
    check("rst_rready", 64'(o_dm_rready), 64'd0);
    check("rst_result", o_result, 64'd0);
    check("rst_rd", 64'(o_rd), 64'd0);
    check("rst_err", 64'(o_err), 64'd0);
    check("rst_araddr", o_dm_araddr, 64'd0);
    check("arprot", 64'(o_dm_arprot), 64'd0);
    #3 rstn = 1'b1;
    step();

    do_load(64'h1000, 64'd3, 3'b000, 5'd1, 64'h0000_0000_8000_0000, 2'b00, 0, 0, 0, 1'b0);
    do_load(64'h1008, 64'hFFFF_FFFF_FFFF_FFFC, 3'b110, 5'd2, 64'h89AB_CDEF_0123_4567, 2'b00, 0, 0, 0, 1'b0);
    do_load(64'h1008, 64'hFFFF_FFFF_FFFF_FFFC, 3'b010, 5'd3, 64'h89AB_CDEF_0123_4567, 2'b00, 0, 0, 0, 1'b0);
    do_load(64'h1001, 64'd0, 3'b001, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 0, 0, 0, 1'b0);
    do_load(64'h1000, 64'd0, 3'b111, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 0, 0, 0, 1'b0);
    do_load(64'h2000, 64'd0, 3'b011, 5'd17, 64'h1234_5678_9ABC_DEF0, 2'b10, 3, 1, 0, 1'b1);
    do_load(64'h3000, 64'd8, 3'b011, 5'd30, 64'hCAFE_F00D_DEAD_BEEF, 2'b00, 1, 2, 4, 1'b0);
    do_load(64'hFFFF_FFFF_FFFF_FFF8, 64'd12, 3'b101, 5'd6, 64'h0000_0000_BEEF_0000, 2'b00, 0, 0, 0, 1'b0);

    // Reset while the R channel is being waited on.
    i_tvalid = 1'b1;
    i_base_addr = 64'h40;
    i_offset = 64'd0;
    i_width = 3'b011;
    i_rd = 5'd9;
    step();
    i_tvalid = 1'b0;
    i_dm_arready = 1'b1;
    step();
    i_dm_arready = 1'b0;
    check("pre_rst_rready", 64'(o_dm_rready), 64'd1);
    #2 rstn = 1'b0;
    #1;
    check("async_rready", 64'(o_dm_rready), 64'd0);
    check("async_valid", 64'(o_valid), 64'd0);
    check("async_tready", 64'(o_tready), 64'd1);
    check("async_arvalid", 64'(o_dm_arvalid), 64'd0);
    step();
    #2 rstn = 1'b1;
    step();
    do_load(64'h10, 64'd0, 3'b100, 5'd11, 64'h1111_1111_1111_11FE, 2'b00, 0, 0, 0, 1'b0);

    for (int it = 0; it < 200; it++) begin
      w = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        r64 = 64'($urandom_range(0, 4095));
        off = {{52{r64[11]}}, r64[11:0]};
      end else begin
        off = {$urandom, $urandom};
      end
      addr = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) addr = addr & ~((64'd1 << w[1:0]) - 64'd1);
      do_load(addr - off, off, w, 5'($urandom_range(0, 31)), {$urandom, $urandom},
              ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
